div_seq: RTL and testbench

- Parametrised multi-cycle integer divider, the successor to the fixed 32-bit unsigned divider.
- Adds signed/unsigned mode per operation, a divide-by-zero flag, a done pulse, registered result hold, and ignore-start-while-busy protection.
- Sits beside the ALU in the multi-cycle CPU datapath. The controller stalls on busy and captures q/r on done for DIV/DIVU.

---
 rtl/div_seq_if.sv | 33 +++
 rtl/div_seq.sv | 147 ++++++++++++++
 tb/tb_div_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Handshake/bus bundle between the CPU controller and the sequential divider.
// Latency: n/a (wiring only).
// Backpressure: none; the controller watches busy and ignores q/r until done.
//
// Signals:
//   dividend, divisor, is_signed, start : controller -> divider, sampled on start
//   q, r, div_zero                      : divider -> controller, held until next done
//   busy, done                          : divider -> controller status
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             start;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;

  // Controller side.
  modport master (
    output dividend, divisor, is_signed, start,
    input  q, r, busy, done, div_zero
  );

  // Divider side.
  modport slave (
    input  dividend, divisor, is_signed, start,
    output q, r, busy, done, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned integer divider (non-restoring, one bit per cycle).
// Latency: start on edge 0, q/r/div_zero/done valid after edge WIDTH+1.
// Backpressure: busy high while in flight; start is ignored (not queued) while busy.
//
// Ports:
//   i_clk   : rising-edge clock
//   i_rst   : asynchronous active-high reset, aborts any operation without done
//   io_div  : div_seq_if slave modport (operands/mode/start in, q/r/flags out)
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  div_seq_if.slave  io_div
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  // Partial remainder, two's complement, one bit wider than the operands.
  logic [WIDTH:0]   r_prem;
  // Dividend magnitude shifts out of the top while quotient bits shift in below.
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  // Untouched dividend, returned as the remainder on divide-by-zero.
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_zero;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH:0]   w_prem_sh;
  logic [WIDTH:0]   w_prem_nxt;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic             w_last;

  // Sign handling only applies in signed mode; unsigned operands with the
  // MSB set are full-range magnitudes. |MIN| = 2^(WIDTH-1) still fits as an
  // unsigned WIDTH-bit magnitude, so negation needs no special case.
  assign w_dvd_neg = io_div.is_signed & io_div.dividend[WIDTH-1];
  assign w_dsr_neg = io_div.is_signed & io_div.divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -io_div.dividend : io_div.dividend;
  assign w_dsr_mag = w_dsr_neg ? -io_div.divisor  : io_div.divisor;

  // Non-restoring step: shift in next dividend bit, then subtract when the
  // partial remainder is non-negative, add when it is negative. Arithmetic
  // wraps mod 2^(WIDTH+1); the post-step value always lies in [-D, D).
  assign w_prem_sh  = {r_prem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_prem_nxt = r_prem[WIDTH] ? (w_prem_sh + {1'b0, r_dsr})
                                    : (w_prem_sh - {1'b0, r_dsr});

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Corrected remainder is in [0, D), so WIDTH-bit wrapping addition is exact.
  assign w_rem_mag = r_prem[WIDTH] ? (r_prem[WIDTH-1:0] + r_dsr)
                                   : r_prem[WIDTH-1:0];

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  // MIN / -1 falls out naturally: magnitude 2^(WIDTH-1) negates to itself.
  always_comb begin
    w_q_fin = r_sign_q ? -r_quo : r_quo;
    w_r_fin = r_sign_r ? -w_rem_mag : w_rem_mag;
    if (r_zero) begin
      w_q_fin = '1;
      w_r_fin = r_dvd_raw;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_prem     <= '0;
      r_quo      <= '0;
      r_dsr      <= '0;
      r_dvd_raw  <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_zero     <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_div.start) begin
            r_state   <= S_CALC;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_prem    <= '0;
            r_quo     <= w_dvd_mag;
            r_dsr     <= w_dsr_mag;
            r_dvd_raw <= io_div.dividend;
            r_sign_q  <= w_dvd_neg ^ w_dsr_neg;
            r_sign_r  <= w_dvd_neg;
            r_zero    <= (io_div.divisor == '0);
          end
        end
        S_CALC: begin
          r_prem <= w_prem_nxt;
          r_quo  <= {r_quo[WIDTH-2:0], ~w_prem_nxt[WIDTH]};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_q        <= w_q_fin;
          r_r        <= w_r_fin;
          r_div_zero <= r_zero;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_div.q        = r_q;
  assign io_div.r        = r_r;
  assign io_div.busy     = r_busy;
  assign io_div.done     = r_done;
  assign io_div.div_zero = r_div_zero;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: a 32-bit and an 8-bit instance, each compared every cycle
// against a latency/arithmetic model, plus directed literal cases.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  div_seq_if #(.WIDTH(32)) if32();
  div_seq_if #(.WIDTH(8))  if8();

  div_seq #(.WIDTH(32)) dut32 (.i_clk(clk), .i_rst(rst), .io_div(if32));
  div_seq #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst(rst), .io_div(if8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference division from plain integer arithmetic: returns {zero, q, r}.
  function automatic logic [64:0] ref_div(input int n, input logic [31:0] a_in,
                                          input logic [31:0] b_in, input logic sgn);
    logic [31:0] mask, a, b, q, r;
    longint sa, sb, lq, lr;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    a = a_in & mask;
    b = b_in & mask;
    if (b == 32'd0) return {1'b1, mask, a};
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[n-1]) sa = sa - (longint'(1) << n);
    if (sgn && b[n-1]) sb = sb - (longint'(1) << n);
    lq = sa / sb;
    lr = sa % sb;
    q = 32'(lq) & mask;
    r = 32'(lr) & mask;
    return {1'b0, q, r};
  endfunction

  function automatic logic [31:0] pick(input int n);
    logic [31:0] mask;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return mask;
      2: return 32'd1 << (n - 1);
      3: return 32'($urandom_range(0, 15));
      4: return mask - 32'($urandom_range(0, 15));
      default: return $urandom & mask;
    endcase
  endfunction

  // ---------------- models: accept start when idle, results WIDTH+1 edges later
  logic [31:0] m32_q, m32_r, m8_q, m8_r;
  logic        m32_z, m32_busy, m32_done, m8_z, m8_busy, m8_done;
  logic [64:0] m32_pend, m8_pend;
  int          m32_left, m8_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m32_q <= 0; m32_r <= 0; m32_z <= 0; m32_busy <= 0; m32_done <= 0;
      m32_left <= 0; m32_pend <= 0;
    end else begin
      m32_done <= 1'b0;
      if (m32_busy) begin
        if (m32_left == 1) begin
          m32_busy <= 1'b0;
          m32_done <= 1'b1;
          {m32_z, m32_q, m32_r} <= m32_pend;
        end
        m32_left <= m32_left - 1;
      end else if (if32.start) begin
        m32_pend <= ref_div(32, if32.dividend, if32.divisor, if32.is_signed);
        m32_busy <= 1'b1;
        m32_left <= 33;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_q <= 0; m8_r <= 0; m8_z <= 0; m8_busy <= 0; m8_done <= 0;
      m8_left <= 0; m8_pend <= 0;
    end else begin
      m8_done <= 1'b0;
      if (m8_busy) begin
        if (m8_left == 1) begin
          m8_busy <= 1'b0;
          m8_done <= 1'b1;
          {m8_z, m8_q, m8_r} <= m8_pend;
        end
        m8_left <= m8_left - 1;
      end else if (if8.start) begin
        m8_pend <= ref_div(8, 32'(if8.dividend), 32'(if8.divisor), if8.is_signed);
        m8_busy <= 1'b1;
        m8_left <= 9;
      end
    end
  end

  // ---------------- per-cycle compare (covers hold-stable between done pulses)
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy32", 32'(if32.busy), 32'(m32_busy));
      chk("done32", 32'(if32.done), 32'(m32_done));
      chk("dz32",   32'(if32.div_zero), 32'(m32_z));
      chk("q32",    if32.q, m32_q);
      chk("r32",    if32.r, m32_r);
      chk("busy8",  32'(if8.busy), 32'(m8_busy));
      chk("done8",  32'(if8.done), 32'(m8_done));
      chk("dz8",    32'(if8.div_zero), 32'(m8_z));
      chk("q8",     32'(if8.q), m8_q);
      chk("r8",     32'(if8.r), m8_r);
    end
  end

  // ---------------- directed 32-bit op with literal expectations
  task automatic run32(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                       input logic ez, input int inject_at);
    int nb, nd;
    logic got;
    logic [31:0] cq, cr;
    logic cz;
    nb = 0; nd = 0; got = 0; cq = 'x; cr = 'x; cz = 1'bx;
    @(negedge clk);
    if32.dividend = a; if32.divisor = b; if32.is_signed = sgn; if32.start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if32.start = (i == inject_at);
      if32.dividend = (i == inject_at) ? 32'd50 : $urandom;
      if32.divisor  = (i == inject_at) ? 32'd3  : $urandom;
      if32.is_signed = $urandom_range(0, 1);
      if (if32.done) begin
        nd++;
        if (!got) begin got = 1; cq = if32.q; cr = if32.r; cz = if32.div_zero; end
      end else if (if32.busy && !got) begin
        nb++;
      end
    end
    if32.start = 1'b0;
    chk({nm, "_q"}, cq, eq);
    chk({nm, "_r"}, cr, er);
    chk({nm, "_dz"}, 32'(cz), 32'(ez));
    chk({nm, "_busycyc"}, 32'(nb), 32'd33);
    chk({nm, "_ndone"}, 32'(nd), 32'd1);
  endtask

  task automatic rand32(input int nops);
    @(negedge clk);
    for (int k = 0; k < nops; k++) begin
      if32.dividend = pick(32); if32.divisor = pick(32);
      if32.is_signed = $urandom_range(0, 1); if32.start = 1'b1;
      @(negedge clk);
      if32.start = 1'b0;
      while (m32_busy) begin
        if32.dividend = $urandom; if32.divisor = $urandom;
        if32.is_signed = $urandom_range(0, 1);
        if32.start = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      if32.start = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic rand8(input int nops);
    @(negedge clk);
    for (int k = 0; k < nops; k++) begin
      if8.dividend = 8'(pick(8)); if8.divisor = 8'(pick(8));
      if8.is_signed = $urandom_range(0, 1); if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      while (m8_busy) begin
        if8.dividend = 8'($urandom); if8.divisor = 8'($urandom);
        if8.is_signed = $urandom_range(0, 1);
        if8.start = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      if8.start = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    logic [64:0] t;
    int nd;
    rst = 1'b1;
    if32.dividend = 0; if32.divisor = 0; if32.is_signed = 0; if32.start = 0;
    if8.dividend = 0;  if8.divisor = 0;  if8.is_signed = 0;  if8.start = 0;

    // Pin the model with hand-computed 8-bit cases.
    t = ref_div(8, 32'h80, 32'hFF, 1'b1);
    chk("model8_min_q", t[63:32], 32'h80);
    chk("model8_min_r", t[31:0], 32'h00);
    t = ref_div(8, 32'hFB, 32'h00, 1'b1);
    chk("model8_zero_q", t[63:32], 32'hFF);
    chk("model8_zero_r", t[31:0], 32'hFB);
    chk("model8_zero_z", 32'(t[64]), 32'd1);

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if32.busy), 32'd0);
    chk("rst_done", 32'(if32.done), 32'd0);
    chk("rst_q", if32.q, 32'd0);
    chk("rst_r", if32.r, 32'd0);
    chk("rst_dz", 32'(if32.div_zero), 32'd0);
    rst = 1'b0;

    run32("u100_7",  32'd100,       32'd7,          1'b0, 32'd14,        32'd2,         1'b0, -1);
    run32("umax_1",  32'hFFFF_FFFF, 32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0, -1);
    run32("sm7_2",   32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, -1);
    run32("s7_m2",   32'd7,         32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, -1);
    run32("sm7_m2",  32'hFFFF_FFF9, 32'hFFFF_FFFE,  1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0, -1);
    run32("um7_2",   32'hFFFF_FFF9, 32'd2,          1'b0, 32'h7FFF_FFFC, 32'd1,         1'b0, -1);
    run32("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,         1'b0, -1);
    run32("u5_0",    32'd5,         32'd0,          1'b0, 32'hFFFF_FFFF, 32'd5,         1'b1, -1);
    run32("sm5_0",   32'hFFFF_FFFB, 32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, -1);
    run32("ign_busy", 32'd100,      32'd7,          1'b0, 32'd14,        32'd2,         1'b0, 9);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    if32.dividend = 32'd100; if32.divisor = 32'd7; if32.is_signed = 1'b0; if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    repeat (14) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(if32.busy), 32'd0);
    chk("arst_done", 32'(if32.done), 32'd0);
    chk("arst_q", if32.q, 32'd0);
    chk("arst_r", if32.r, 32'd0);
    chk("arst_dz", 32'(if32.div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (if32.done) nd++;
    end
    chk("arst_no_done", 32'(nd), 32'd0);
    run32("post_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, -1);

    fork
      rand32(1200);
      rand8(3500);
    join

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
